// File: rtl/vga_frame_capture.sv
// vga_frame_capture
//   Samples a 640x480@60 VGA stream (active-low syncs, 8-bit RGB, one pixel
//   per clk) and writes one IMG_W x IMG_H window of 8-bit pixels into the
//   image RAM write port. One-shot: armed by start, captures the next full
//   frame, pulses done, returns to idle.
//   Build option: define VGA_CAP_GRAY_EN to store (R + 2G + B) >> 2 instead
//   of the red channel. Latency is the same in both builds.
//
// RAM write port handshake: the RAM is always ready, so there is no ready
// signal. A write happens in every cycle where wr_en is 1; wr_addr and
// wr_data are valid only in those cycles.
//
// Pipeline: pixel at inputs in cycle n -> input registers in cycle n+1
// (position and window decision computed here) -> write port registers
// present the write in cycle n+2.
module vga_frame_capture #(
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BACK = 48,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BACK = 33,
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned X_OFF  = 0,
    parameter int unsigned Y_OFF  = 0,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [7:0]        red_in,
    input  logic [7:0]        green_in,
    input  logic [7:0]        blue_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    // Window bounds expressed directly in raw counter units, so negative
    // active coordinates never need a signed compare.
    localparam int unsigned X_LO = H_SYNC + H_BACK + X_OFF;
    localparam int unsigned X_HI = X_LO + IMG_W;
    localparam int unsigned Y_LO = V_SYNC + V_BACK + Y_OFF;
    localparam int unsigned Y_HI = Y_LO + IMG_H;
    localparam int unsigned XW   = $clog2(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              hs_r;
    logic              vs_r;
    logic              hs_rr;
    logic              vs_rr;
    logic [7:0]        pix_in;
    logic [7:0]        pix_r;
    logic              hs_fall;
    logic              vs_fall;
    logic [10:0]       hcnt;
    logic [10:0]       h_pos;
    logic [9:0]        vcnt;
    logic [9:0]        v_pos;
    logic              in_win;
    logic [ADDR_W-1:0] x_rel;
    logic [ADDR_W-1:0] y_rel;
    logic [ADDR_W-1:0] addr_d;
    logic              wr_fire;
    logic              last_wr;

`ifdef VGA_CAP_GRAY_EN
    // Luma approximation with green weighted twice; 10-bit sum, truncated.
    logic [9:0] gray_sum;
    assign gray_sum = {2'b00, red_in} + {1'b0, green_in, 1'b0} + {2'b00, blue_in};
    assign pix_in   = 8'(gray_sum >> 2);
`else
    // Red channel only, matching the red-only image path.
    logic unused_chan;
    assign unused_chan = ^{green_in, blue_in};
    assign pix_in      = red_in;
`endif

    // Input stage: one register on syncs and pixel, a second on syncs for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_r  <= 1'b1;
            vs_r  <= 1'b1;
            hs_rr <= 1'b1;
            vs_rr <= 1'b1;
            pix_r <= '0;
        end else begin
            hs_r  <= hsync_in;
            vs_r  <= vsync_in;
            hs_rr <= hs_r;
            vs_rr <= vs_r;
            pix_r <= pix_in;
        end
    end

    assign hs_fall = hs_rr & ~hs_r;
    assign vs_fall = vs_rr & ~vs_r;

    // Position of the pixel now in the input registers: cleared on sync fall, saturating.
    always_comb begin
        h_pos = hcnt;
        v_pos = vcnt;
        if (hs_fall) begin
            h_pos = '0;
        end else if (!(&hcnt)) begin
            h_pos = hcnt + 11'd1;
        end
        if (vs_fall) begin
            v_pos = '0;
        end else if (hs_fall && !(&vcnt)) begin
            v_pos = vcnt + 10'd1;
        end
    end

    // Counter registers hold the position of the previous registered pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= h_pos;
            vcnt <= v_pos;
        end
    end

    // Window test and write address; IMG_W is a power of two so the address is a concat.
    always_comb begin
        in_win = (32'(h_pos) >= X_LO) && (32'(h_pos) < X_HI) &&
                 (32'(v_pos) >= Y_LO) && (32'(v_pos) < Y_HI);
        x_rel  = ADDR_W'(32'(h_pos) - X_LO);
        y_rel  = ADDR_W'(32'(v_pos) - Y_LO);
        addr_d = (y_rel << XW) | x_rel;
    end

    assign wr_fire = (state == ST_CAPTURE) && in_win;
    assign last_wr = wr_en && (wr_addr == LAST_ADDR);

    // Write port registers; address and data only move on an actual write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= wr_fire;
            if (wr_fire) begin
                wr_addr <= addr_d;
                wr_data <= pix_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and status outputs. An early Vsync in CAPTURE simply
    // stays in CAPTURE: the new frame starts again at address 0.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                busy = 1'b1;
                if (vs_fall) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                busy = 1'b1;
                if (last_wr) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sticky abort flag: set by a Vsync that interrupts a capture, cleared by a fresh start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            frame_err <= 1'b0;
        end else if ((state == ST_CAPTURE) && vs_fall && !last_wr) begin
            frame_err <= 1'b1;
        end
    end

endmodule
